ram_arbiter: RTL and testbench

Two-requester access controller for the shared 8x256 dual-port RAM (separate write and read address ports, 1-cycle registered read). After reset it sequences a full-memory clear. It then arbitrates requesters A and B onto the RAM's write and read ports with round-robin fairness, granting both in one cycle when their accesses do not conflict. It sits directly between the RAM instance and its two clients.

---
 rtl/ram_ctrl_pkg.sv | 22 ++
 rtl/ram_rr_arb2.sv | 50 +++++
 rtl/ram_arbiter.sv | 142 ++++++++++++++
 tb/tb_ram_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types and default sizes for the two-requester RAM access controller.
// Imported by the arbiter core and the top-level controller.
package ram_ctrl_pkg;

    localparam int MEM_WIDTH_DEF = 8;
    localparam int MEM_DEPTH_DEF = 256;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    typedef enum logic {
        REQ_A,
        REQ_B
    } req_id_t;

    function automatic req_id_t other_req(input req_id_t id);
        return (id == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/ram_rr_arb2.sv
// Combinational two-requester round-robin grant logic with write/read pairing:
// a write and a read to different addresses can both be granted in one cycle.
module ram_rr_arb2
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 en,
    input  req_id_t              ptr,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [ADDR_SIZE-1:0] a_addr,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [ADDR_SIZE-1:0] b_addr,
    output logic                 a_gnt,
    output logic                 b_gnt,
    output req_id_t              ptr_next
);

    logic pairable;

    // A write and a read never collide on the RAM unless they hit the same word.
    assign pairable = (a_we != b_we) && (a_addr != b_addr);

    always_comb begin
        a_gnt    = 1'b0;
        b_gnt    = 1'b0;
        ptr_next = ptr;
        if (en) begin
            if (a_req && !b_req) begin
                a_gnt    = 1'b1;
                ptr_next = REQ_B;
            end else if (b_req && !a_req) begin
                b_gnt    = 1'b1;
                ptr_next = REQ_A;
            end else if (a_req && b_req) begin
                if (pairable) begin
                    a_gnt = 1'b1;
                    b_gnt = 1'b1;
                end else begin
                    a_gnt    = (ptr == REQ_A);
                    b_gnt    = (ptr == REQ_B);
                    ptr_next = other_req(ptr);
                end
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Access controller for a shared dual-port RAM: clears the memory after reset,
// then arbitrates requesters A and B onto the RAM write and read ports.
module ram_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int MEM_WIDTH = MEM_WIDTH_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int ADDR_SIZE = $clog2(MEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [ADDR_SIZE-1:0] a_addr,
    input  logic [MEM_WIDTH-1:0] a_wdata,
    output logic                 a_gnt,
    output logic                 a_rvalid,
    output logic [MEM_WIDTH-1:0] a_rdata,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [ADDR_SIZE-1:0] b_addr,
    input  logic [MEM_WIDTH-1:0] b_wdata,
    output logic                 b_gnt,
    output logic                 b_rvalid,
    output logic [MEM_WIDTH-1:0] b_rdata,
    output logic                 init_done,
    output logic                 ram_wr_en,
    output logic [ADDR_SIZE-1:0] ram_addr_wr,
    output logic [MEM_WIDTH-1:0] ram_din,
    output logic                 ram_rd_en,
    output logic [ADDR_SIZE-1:0] ram_addr_rd,
    input  logic [MEM_WIDTH-1:0] ram_dout
);

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    state_t               state_reg, state_next;
    logic [ADDR_SIZE-1:0] cnt_reg, cnt_next;
    req_id_t              ptr_reg, ptr_next, arb_ptr;
    logic                 arb_en;
    logic [1:0]           gnt_vec, we_vec, rvalid_reg, rvalid_out;
    logic [MEM_WIDTH-1:0] rdata_out [2];

    assign arb_en    = (state_reg == ST_RUN) && !rst;
    assign init_done = (state_reg == ST_RUN) && !rst;

    ram_rr_arb2 #(
        .ADDR_SIZE (ADDR_SIZE)
    ) u_arb (
        .en       (arb_en),
        .ptr      (ptr_reg),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .a_gnt    (gnt_vec[0]),
        .b_gnt    (gnt_vec[1]),
        .ptr_next (arb_ptr)
    );

    assign we_vec = {b_we, a_we};
    assign a_gnt  = gnt_vec[0];
    assign b_gnt  = gnt_vec[1];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            ST_INIT: begin
                cnt_next = cnt_reg + ADDR_SIZE'(1);
                if (cnt_reg == LAST_ADDR) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                ptr_next = arb_ptr;
            end
            default: state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_INIT;
            cnt_reg    <= '0;
            ptr_reg    <= REQ_A;
            rvalid_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            ptr_reg    <= ptr_next;
            rvalid_reg <= gnt_vec & ~we_vec;
        end
    end

    // Read data is steered to whichever requester owns the read issued last cycle;
    // outputs are masked during reset so a read in flight never surfaces.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_ret
        assign rvalid_out[gi] = rvalid_reg[gi] & ~rst;
        assign rdata_out[gi]  = rvalid_out[gi] ? ram_dout : '0;
    end

    assign a_rvalid = rvalid_out[0];
    assign b_rvalid = rvalid_out[1];
    assign a_rdata  = rdata_out[0];
    assign b_rdata  = rdata_out[1];

    always_comb begin
        ram_wr_en   = 1'b0;
        ram_addr_wr = '0;
        ram_din     = '0;
        ram_rd_en   = 1'b0;
        ram_addr_rd = '0;
        if (!rst) begin
            if (state_reg == ST_INIT) begin
                ram_wr_en   = 1'b1;
                ram_addr_wr = cnt_reg;
            end else begin
                if (a_gnt && a_we) begin
                    ram_wr_en   = 1'b1;
                    ram_addr_wr = a_addr;
                    ram_din     = a_wdata;
                end else if (b_gnt && b_we) begin
                    ram_wr_en   = 1'b1;
                    ram_addr_wr = b_addr;
                    ram_din     = b_wdata;
                end
                if (a_gnt && !a_we) begin
                    ram_rd_en   = 1'b1;
                    ram_addr_rd = a_addr;
                end else if (b_gnt && !b_we) begin
                    ram_rd_en   = 1'b1;
                    ram_addr_rd = b_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM, directed vectors that
// queue expected read data, and a monitor that checks every returned read.
module tb_ram_arbiter;

    localparam int W  = 8;
    localparam int D  = 256;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [W-1:0]  a_wdata = '0, b_wdata = '0;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid, init_done;
    logic [W-1:0]  a_rdata, b_rdata;
    logic          ram_wr_en, ram_rd_en;
    logic [AW-1:0] ram_addr_wr, ram_addr_rd;
    logic [W-1:0]  ram_din;
    logic [W-1:0]  ram_dout = '0;

    logic [W-1:0]  mem [D];
    logic [W-1:0]  qa [$];
    logic [W-1:0]  qb [$];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    ram_arbiter #(
        .MEM_WIDTH (W),
        .MEM_DEPTH (D),
        .ADDR_SIZE (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .a_req       (a_req),
        .a_we        (a_we),
        .a_addr      (a_addr),
        .a_wdata     (a_wdata),
        .a_gnt       (a_gnt),
        .a_rvalid    (a_rvalid),
        .a_rdata     (a_rdata),
        .b_req       (b_req),
        .b_we        (b_we),
        .b_addr      (b_addr),
        .b_wdata     (b_wdata),
        .b_gnt       (b_gnt),
        .b_rvalid    (b_rvalid),
        .b_rdata     (b_rdata),
        .init_done   (init_done),
        .ram_wr_en   (ram_wr_en),
        .ram_addr_wr (ram_addr_wr),
        .ram_din     (ram_din),
        .ram_rd_en   (ram_rd_en),
        .ram_addr_rd (ram_addr_rd),
        .ram_dout    (ram_dout)
    );

    // Behavioural dual-port RAM with one-cycle registered read.
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr_wr] <= ram_din;
        if (ram_rd_en) ram_dout <= mem[ram_addr_rd];
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: every presented read is matched against the scoreboard queues.
    initial begin
        forever begin
            @(negedge clk);
            if (a_rvalid) begin
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_rvalid_unexpected: got rdata 0x%0h expected no read", a_rdata);
                end else begin
                    chk("a_rdata", int'(a_rdata), int'(qa.pop_front()));
                end
            end else begin
                chk("a_rdata_idle", int'(a_rdata), 0);
            end
            if (b_rvalid) begin
                if (qb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_rvalid_unexpected: got rdata 0x%0h expected no read", b_rdata);
                end else begin
                    chk("b_rdata", int'(b_rdata), int'(qb.pop_front()));
                end
            end else begin
                chk("b_rdata_idle", int'(b_rdata), 0);
            end
        end
    end

    task automatic set_idle();
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic apply_rst(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
            set_idle();
            @(negedge clk);
            chk("rst_wr_en", int'(ram_wr_en), 0);
            chk("rst_rd_en", int'(ram_rd_en), 0);
            chk("rst_init_done", int'(init_done), 0);
            chk("rst_a_rvalid", int'(a_rvalid), 0);
            $display("reset cycle %0d: wr_en=%0d init_done=%0d", i, ram_wr_en, init_done);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Called in cycle 0 after reset release; checks clear writes 0..last.
    task automatic check_clear(input int last);
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h01;
        b_req = 1'b1; b_we = 1'b1; b_addr = 8'h02; b_wdata = 8'hEE;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            chk("clear_wr_en", int'(ram_wr_en), 1);
            chk("clear_addr", int'(ram_addr_wr), k);
            chk("clear_din", int'(ram_din), 0);
            chk("clear_init_done", int'(init_done), 0);
            chk("clear_gnt", int'({a_gnt, b_gnt, ram_rd_en}), 0);
            if (k < last) @(posedge clk);
        end
        $display("clear checked through address 0x%0h", last);
    endtask

    task automatic do_cycle(input string tag,
                            input logic ar, input logic aw, input logic [7:0] aa, input logic [7:0] ad,
                            input logic br, input logic bw, input logic [7:0] ba, input logic [7:0] bd,
                            input logic ega, input logic egb,
                            input logic [7:0] ea, input logic [7:0] eb, input bit push);
        @(posedge clk);
        #1;
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        @(negedge clk);
        chk({tag, " a_gnt"}, int'(a_gnt), int'(ega));
        chk({tag, " b_gnt"}, int'(b_gnt), int'(egb));
        chk({tag, " init_done"}, int'(init_done), 1);
        if (push && ega && ar && !aw) qa.push_back(ea);
        if (push && egb && br && !bw) qb.push_back(eb);
        $display("%s: a_gnt=%0d b_gnt=%0d wr_en=%0d rd_en=%0d", tag, a_gnt, b_gnt, ram_wr_en, ram_rd_en);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        apply_rst(2);
        check_clear(D - 1);
        //        tag        ar aw  aa     ad     br bw  ba     bd     ga gb  ea     eb     push
        do_cycle("rd00",    1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 1);
        do_cycle("rd7f",    1, 0, 8'h7F, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 1);
        do_cycle("rdff",    1, 0, 8'hFF, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 1);
        do_cycle("wr10",    1, 1, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 1);
        do_cycle("rd10",    1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'h5A, 8'h00, 1);
        do_cycle("b_rd00",  0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00, 1);
        do_cycle("ww0",     1, 1, 8'h20, 8'h11, 1, 1, 8'h21, 8'h22, 1, 0, 8'h00, 8'h00, 1);
        do_cycle("ww1",     1, 1, 8'h20, 8'h11, 1, 1, 8'h21, 8'h22, 0, 1, 8'h00, 8'h00, 1);
        do_cycle("ww2",     1, 1, 8'h20, 8'h11, 1, 1, 8'h21, 8'h22, 1, 0, 8'h00, 8'h00, 1);
        do_cycle("ww3",     1, 1, 8'h20, 8'h11, 1, 1, 8'h21, 8'h22, 0, 1, 8'h00, 8'h00, 1);
        do_cycle("rr",      1, 0, 8'h20, 8'h00, 1, 0, 8'h21, 8'h00, 1, 0, 8'h11, 8'h00, 1);
        do_cycle("rr_b",    0, 0, 8'h00, 8'h00, 1, 0, 8'h21, 8'h00, 0, 1, 8'h00, 8'h22, 1);
        do_cycle("wr_rd",   1, 1, 8'h30, 8'hC3, 1, 0, 8'h31, 8'h00, 1, 1, 8'h00, 8'h00, 1);
        do_cycle("conf",    1, 1, 8'h40, 8'h99, 1, 0, 8'h40, 8'h00, 1, 0, 8'h00, 8'h00, 1);
        do_cycle("conf_b",  0, 0, 8'h00, 8'h00, 1, 0, 8'h40, 8'h00, 0, 1, 8'h00, 8'h99, 1);
        do_cycle("conf2",   1, 0, 8'h41, 8'h00, 1, 1, 8'h41, 8'h77, 1, 0, 8'h00, 8'h00, 1);
        do_cycle("conf2_b", 0, 0, 8'h00, 8'h00, 1, 1, 8'h41, 8'h77, 0, 1, 8'h00, 8'h00, 1);
        do_cycle("rd41",    1, 0, 8'h41, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'h77, 8'h00, 1);
        do_cycle("conf3",   1, 1, 8'h50, 8'hAA, 1, 0, 8'h50, 8'h00, 0, 1, 8'h00, 8'h00, 1);
        do_cycle("conf3_a", 1, 1, 8'h50, 8'hAA, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 1);
        do_cycle("rd30",    0, 0, 8'h00, 8'h00, 1, 0, 8'h30, 8'h00, 0, 1, 8'h00, 8'hC3, 1);
        do_cycle("idle",    0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1);
        // Read granted right before reset: its data must never be presented.
        do_cycle("pend",    1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0);
        apply_rst(2);
        check_clear(8'h7F);
        apply_rst(2);
        check_clear(D - 1);
        do_cycle("post_rd10", 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 1);
        do_cycle("post_rd50", 0, 0, 8'h00, 8'h00, 1, 0, 8'h50, 8'h00, 0, 1, 8'h00, 8'h00, 1);
        do_cycle("idle2",     0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1);
        do_cycle("idle3",     0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
